// File: rtl/phase_sequencer.sv
// phase_sequencer: execution-phase generator and run/halt/step control for the multicycle core
module phase_sequencer #(
    parameter int         NUM_PHASES = 5,
    parameter int         CNT_W      = 16,
    parameter logic [3:0] HLT_CODE   = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_mode,
    input  logic [15:0]      instruction,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             phase_last,
    output logic [CNT_W-1:0] instr_count
);
    localparam logic [2:0] LAST = 3'(NUM_PHASES);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state;
    logic   is_hlt;
    logic   unused_instr;
    assign is_hlt       = instruction[15:14] == 2'b11 && instruction[7:4] == HLT_CODE;
    assign unused_instr = ^{instruction[13:8], instruction[3:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= 3'd0;
            running     <= 1'b0;
            halted      <= 1'b0;
            phase_last  <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                RUN: if (phase == 3'd2 && is_hlt) begin
                    state      <= HALT;
                    phase      <= 3'd0;
                    running    <= 1'b0;
                    halted     <= 1'b1;
                    phase_last <= 1'b0;
                end else if (phase == LAST) begin
                    // step_mode only matters at the instruction boundary
                    instr_count <= instr_count + CNT_W'(1);
                    state       <= step_mode ? IDLE : RUN;
                    phase       <= step_mode ? 3'd0 : 3'd1;
                    running     <= !step_mode;
                    phase_last  <= 1'b0;
                end else begin
                    phase      <= phase + 3'd1;
                    phase_last <= phase + 3'd1 == LAST;
                end
                default: if (run_req) begin
                    state      <= RUN;
                    phase      <= 3'd1;
                    running    <= 1'b1;
                    halted     <= 1'b0;
                    phase_last <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: scoreboard bench for phase_sequencer, one 5-phase/4-bit-count
// instance and one 3-phase instance driven in turn.
module tb_phase_sequencer;
    logic        clk = 1'b0;
    logic        rst_a = 1'b1, run_a = 1'b0, step_a = 1'b0;
    logic        rst_b = 1'b1, run_b = 1'b0, step_b = 1'b0;
    logic [15:0] ins_a = '0, ins_b = '0;
    logic [2:0]  ph_a, ph_b;
    logic        running_a, halted_a, last_a, running_b, halted_b, last_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    int checks = 0, failures = 0, n = 0;

    typedef struct {int st; int ph; int cnt;} ms_t;
    typedef struct {int ph; int run; int hlt; int last; int cnt;} exp_t;
    ms_t  ms_a, ms_b;
    exp_t q[$];

    always #5 clk = ~clk;

    phase_sequencer #(.NUM_PHASES(5), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst_a), .run_req(run_a), .step_mode(step_a), .instruction(ins_a),
        .phase(ph_a), .running(running_a), .halted(halted_a), .phase_last(last_a),
        .instr_count(cnt_a));

    phase_sequencer #(.NUM_PHASES(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst_b), .run_req(run_b), .step_mode(step_b), .instruction(ins_b),
        .phase(ph_b), .running(running_b), .halted(halted_b), .phase_last(last_b),
        .instr_count(cnt_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // st: 0 idle, 1 run, 2 halt
    function automatic ms_t model(ms_t s, int np, int cw, bit r, bit rr, bit sm, logic [15:0] ins);
        ms_t x = s;
        if (r) begin
            x.st = 0; x.ph = 0; x.cnt = 0;
        end else if (s.st != 1) begin
            if (rr) begin x.st = 1; x.ph = 1; end
        end else if (s.ph == 2 && ins[15:14] == 2'b11 && ins[7:4] == 4'hF) begin
            x.st = 2; x.ph = 0;
        end else if (s.ph == np) begin
            x.cnt = (s.cnt + 1) % (1 << cw);
            x.st  = sm ? 0 : 1;
            x.ph  = sm ? 0 : 1;
        end else begin
            x.ph = s.ph + 1;
        end
        return x;
    endfunction

    task automatic cyc(input bit b, input bit r, input bit rr, input bit sm, input logic [15:0] ins);
        ms_t   s;
        exp_t  e;
        string p;
        @(negedge clk);
        if (b) begin
            rst_b = r; run_b = rr; step_b = sm; ins_b = ins;
            ms_b = model(ms_b, 3, 16, r, rr, sm, ins);
            s = ms_b;
        end else begin
            rst_a = r; run_a = rr; step_a = sm; ins_a = ins;
            ms_a = model(ms_a, 5, 4, r, rr, sm, ins);
            s = ms_a;
        end
        e.ph = s.ph; e.run = int'(s.st == 1); e.hlt = int'(s.st == 2);
        e.last = int'(s.ph == (b ? 3 : 5)); e.cnt = s.cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        n++;
        p = $sformatf("%s%0d", b ? "B" : "A", n);
        check({p, "_phase"},   b ? 32'(ph_b) : 32'(ph_a), 32'(e.ph));
        check({p, "_running"}, b ? 32'(running_b) : 32'(running_a), 32'(e.run));
        check({p, "_halted"},  b ? 32'(halted_b) : 32'(halted_a), 32'(e.hlt));
        check({p, "_last"},    b ? 32'(last_b) : 32'(last_a), 32'(e.last));
        check({p, "_count"},   b ? 32'(cnt_b) : 32'(cnt_a), 32'(e.cnt));
    endtask

    initial begin
        cyc(0, 1, 0, 0, 16'h0000);
        cyc(0, 1, 0, 0, 16'h0000);
        cyc(0, 1, 1, 0, 16'h0000);
        cyc(0, 0, 0, 0, 16'h0000);
        check("A_no_start_after_rst", 32'(ph_a), 0);
        cyc(0, 0, 1, 0, 16'h0000);
        repeat (12) cyc(0, 0, 0, 0, 16'h0000);
        // run_req ignored while running; near-miss HLT encodings must not halt
        repeat (3) cyc(0, 0, 1, 0, 16'hC0E0);
        repeat (6) cyc(0, 0, 0, 0, 16'h00F0);
        for (int i = 0; i < 8 && ms_a.st != 2; i++) cyc(0, 0, 0, 0, 16'hC0F0);
        check("A_halt_reached", 32'(halted_a), 1);
        repeat (2) cyc(0, 0, 0, 1, 16'hC0F0);
        cyc(0, 0, 1, 1, 16'h0000);
        check("A_resume_phase", 32'(ph_a), 1);
        repeat (6) cyc(0, 0, 0, 1, 16'h0000);
        check("A_step_idle", 32'(running_a), 0);
        cyc(0, 0, 1, 1, 16'h0000);
        repeat (2) cyc(0, 0, 0, 1, 16'h0000);
        repeat (4) cyc(0, 0, 0, 0, 16'h0000);
        check("A_step_late_toggle_runs", 32'(running_a), 1);
        repeat (90) cyc(0, 0, 0, 0, 16'h1234);
        for (int i = 0; i < 8 && ms_a.ph != 3; i++) cyc(0, 0, 0, 0, 16'h0000);
        cyc(0, 1, 1, 0, 16'h0000);
        check("A_rst_mid_count", 32'(cnt_a), 0);
        cyc(0, 0, 0, 0, 16'h0000);

        cyc(1, 1, 0, 0, 16'h0000);
        cyc(1, 1, 0, 0, 16'h0000);
        cyc(1, 0, 1, 0, 16'h0000);
        repeat (8) cyc(1, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 6 && ms_b.st != 2; i++) cyc(1, 0, 0, 0, 16'hC0F0);
        check("B_halt_reached", 32'(halted_b), 1);
        cyc(1, 0, 1, 0, 16'h0000);
        repeat (4) cyc(1, 0, 0, 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
